// File: rtl/i2s_clk_gen.sv
// I2S clock master: programmable mclk divider feeding a bclk/lrclk chain with
// frame-aligned start/stop, plus bit position and strobe outputs for serializers.
module i2s_clk_gen #(
   parameter int DIV_W         = 8,
   parameter int MCLK_PER_BCLK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] mclk_half,
   input  logic             frame_sel,
   input  logic             i2s_mode,
   output logic             mclk,
   output logic             bclk,
   output logic             lrclk,
   output logic             busy,
   output logic [5:0]       bit_idx,
   output logic             shift_en,
   output logic             frame_start
);

   localparam int T_W = (MCLK_PER_BCLK > 1) ? $clog2(MCLK_PER_BCLK) : 1;
   localparam logic [T_W-1:0] T_LAST = T_W'(MCLK_PER_BCLK - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] h_q, h_d;
   logic [DIV_W-1:0] c_q, c_d;
   logic [T_W-1:0]   t_q, t_d;
   logic             n64_q, n64_d;
   logic             mode_q, mode_d;
   logic             mclk_q, mclk_d;
   logic             bclk_q, bclk_d;
   logic             lrclk_q, lrclk_d;
   logic             busy_q, busy_d;
   logic [5:0]       bit_idx_q, bit_idx_d;
   logic             shift_en_q, shift_en_d;
   logic             frame_start_q, frame_start_d;
   logic [5:0]       idx_last;
   logic [5:0]       idx_next;

   // Philips mode looks one bit ahead so lrclk flips a bit early.
   function automatic logic lr_of(input logic [5:0] idx, input logic n64, input logic phil);
      logic [5:0] last;
      logic [5:0] pos;
      last = n64 ? 6'd63 : 6'd31;
      pos  = phil ? ((idx == last) ? 6'd0 : idx + 6'd1) : idx;
      return n64 ? pos[5] : pos[4];
   endfunction

   always_comb begin
      state_d       = state_q;
      h_d           = h_q;
      c_d           = c_q;
      t_d           = t_q;
      n64_d         = n64_q;
      mode_d        = mode_q;
      mclk_d        = mclk_q;
      bclk_d        = bclk_q;
      lrclk_d       = lrclk_q;
      busy_d        = busy_q;
      bit_idx_d     = bit_idx_q;
      shift_en_d    = 1'b0;
      frame_start_d = 1'b0;
      idx_last      = n64_q ? 6'd63 : 6'd31;
      idx_next      = (bit_idx_q == idx_last) ? 6'd0 : bit_idx_q + 6'd1;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d       = RUN;
               h_d           = (mclk_half == '0) ? DIV_W'(1) : mclk_half;
               n64_d         = frame_sel;
               mode_d        = i2s_mode;
               c_d           = '0;
               t_d           = '0;
               mclk_d        = 1'b0;
               bclk_d        = 1'b0;
               lrclk_d       = 1'b0;
               bit_idx_d     = 6'd0;
               busy_d        = 1'b1;
               frame_start_d = 1'b1;
            end
         end
         RUN: begin
            if (c_q == h_q - DIV_W'(1)) begin
               c_d    = '0;
               mclk_d = ~mclk_q;
               if (t_q == T_LAST) begin
                  t_d    = '0;
                  bclk_d = ~bclk_q;
                  if (bclk_q) begin
                     // Falling bclk: the only place bits advance and stop is honoured.
                     if (idx_next == 6'd0 && !en) begin
                        state_d   = IDLE;
                        mclk_d    = 1'b0;
                        bclk_d    = 1'b0;
                        lrclk_d   = 1'b0;
                        bit_idx_d = 6'd0;
                        busy_d    = 1'b0;
                     end else begin
                        shift_en_d    = 1'b1;
                        bit_idx_d     = idx_next;
                        lrclk_d       = lr_of(idx_next, n64_q, mode_q);
                        frame_start_d = (idx_next == 6'd0);
                     end
                  end
               end else begin
                  t_d = t_q + T_W'(1);
               end
            end else begin
               c_d = c_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         h_q           <= '0;
         c_q           <= '0;
         t_q           <= '0;
         n64_q         <= 1'b0;
         mode_q        <= 1'b0;
         mclk_q        <= 1'b0;
         bclk_q        <= 1'b0;
         lrclk_q       <= 1'b0;
         busy_q        <= 1'b0;
         bit_idx_q     <= 6'd0;
         shift_en_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_q           <= h_d;
         c_q           <= c_d;
         t_q           <= t_d;
         n64_q         <= n64_d;
         mode_q        <= mode_d;
         mclk_q        <= mclk_d;
         bclk_q        <= bclk_d;
         lrclk_q       <= lrclk_d;
         busy_q        <= busy_d;
         bit_idx_q     <= bit_idx_d;
         shift_en_q    <= shift_en_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign mclk        = mclk_q;
   assign bclk        = bclk_q;
   assign lrclk       = lrclk_q;
   assign busy        = busy_q;
   assign bit_idx     = bit_idx_q;
   assign shift_en    = shift_en_q;
   assign frame_start = frame_start_q;

endmodule
